// File: rtl/wb_arbiter2.sv
// wb_arbiter2 - two-master, one-slave Wishbone classic arbiter (registered-ack slave).
//
// Shares one slave (typically on-chip BRAM) between two bus masters, e.g. a CPU
// and a DMA engine. Grants are round-robin and held for the owner's whole cyc.
// IDLE always separates two owners, so the slave sees cyc/stb low and can drop
// its held ack. A timeout guard errors an owner whose strobe goes unanswered.
//
// Parameters
//   ADDR_WIDTH  width of all address ports
//   TIMEOUT     stalled strobe cycles before the arbiter errors the owner (0 = off)
//
// Ports
//   sys_clk_i            clock, everything on the rising edge
//   sys_rst_i            synchronous active-high reset
//   mN_cyc_i / mN_stb_i  master N bus request and strobe (N = 0, 1)
//   mN_we_i / mN_sel_i   master N write enable and byte selects
//   mN_adr_i / mN_mosi_i master N byte address and write data
//   mN_miso_o            read data returned to master N (0 unless owner)
//   mN_ack_o / mN_err_o  ack / err returned to master N (0 unless owner)
//   s_cyc_o .. s_mosi_o  owner's request routed to the slave
//   s_miso_i             slave read data
//   s_ack_i / s_err_i    slave ack / err, held high until stb drops

module wb_arbiter2 #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  sys_clk_i,
  input  logic                  sys_rst_i,

  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_sel_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [31:0]           m0_mosi_i,
  output logic [31:0]           m0_miso_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,

  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_sel_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [31:0]           m1_mosi_i,
  output logic [31:0]           m1_miso_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,

  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [3:0]            s_sel_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [31:0]           s_mosi_o,
  input  logic [31:0]           s_miso_i,
  input  logic                  s_ack_i,
  input  logic                  s_err_i
);

  // Counter wide enough to reach TIMEOUT; one dummy bit when the guard is off.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            to_hit_q, to_hit_d;

  logic                  own0, own1;
  logic                  own_cyc, own_stb, own_we;
  logic [3:0]            own_sel;
  logic [ADDR_WIDTH-1:0] own_adr;
  logic [31:0]           own_mosi;
  logic                  stall;

  // Reset masks ownership immediately so an aborted transfer forwards nothing
  // to either side during the reset cycle itself.
  assign own0 = (state_q == OWN0) && !sys_rst_i;
  assign own1 = (state_q == OWN1) && !sys_rst_i;

  // Route the current owner's request; everything is zero while idle.
  always_comb begin
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_sel  = '0;
    own_adr  = '0;
    own_mosi = '0;
    if (own0) begin
      own_cyc  = m0_cyc_i;
      own_stb  = m0_stb_i;
      own_we   = m0_we_i;
      own_sel  = m0_sel_i;
      own_adr  = m0_adr_i;
      own_mosi = m0_mosi_i;
    end else if (own1) begin
      own_cyc  = m1_cyc_i;
      own_stb  = m1_stb_i;
      own_we   = m1_we_i;
      own_sel  = m1_sel_i;
      own_adr  = m1_adr_i;
      own_mosi = m1_mosi_i;
    end
  end

  // After a timeout the strobe is withheld from the slave so it never sees a
  // stale request while the owner is still being errored.
  assign s_cyc_o  = own_cyc;
  assign s_stb_o  = own_stb & ~to_hit_q;
  assign s_we_o   = own_we;
  assign s_sel_o  = own_sel;
  assign s_adr_o  = own_adr;
  assign s_mosi_o = own_mosi;

  // The arbiter-generated err lasts only while the owner keeps its strobe up.
  assign m0_miso_o = own0 ? s_miso_i : 32'h0;
  assign m0_ack_o  = own0 & s_ack_i & ~to_hit_q;
  assign m0_err_o  = own0 & ((s_err_i & ~to_hit_q) | (to_hit_q & m0_stb_i));
  assign m1_miso_o = own1 ? s_miso_i : 32'h0;
  assign m1_ack_o  = own1 & s_ack_i & ~to_hit_q;
  assign m1_err_o  = own1 & ((s_err_i & ~to_hit_q) | (to_hit_q & m1_stb_i));

  assign stall = s_stb_o & ~s_ack_i & ~s_err_i;

  // Next-state: arbitration from IDLE, release on cyc low, timeout tracking.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    tcnt_d   = tcnt_q;
    to_hit_d = to_hit_q;
    case (state_q)
      IDLE: begin
        tcnt_d   = '0;
        to_hit_d = 1'b0;
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (m0_cyc_i) begin
          state_d = OWN0;
        end else if (m1_cyc_i) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (!own_cyc) begin
          state_d  = IDLE;
          last_d   = (state_q == OWN1);
          tcnt_d   = '0;
          to_hit_d = 1'b0;
        end else if (TIMEOUT > 0) begin
          if (to_hit_q) begin
            tcnt_d = '0;
            if (!own_stb) begin
              to_hit_d = 1'b0;
            end
          end else if (stall) begin
            if (tcnt_q == TW'(TIMEOUT - 1)) begin
              to_hit_d = 1'b1;
            end
            if (tcnt_q != '1) begin
              tcnt_d = tcnt_q + 1'b1;
            end
          end else begin
            tcnt_d = '0;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        tcnt_d   = '0;
        to_hit_d = 1'b0;
      end
    endcase
  end

  // State registers; reset lets master 0 win the first tie.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      tcnt_q   <= '0;
      to_hit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      tcnt_q   <= tcnt_d;
      to_hit_q <= to_hit_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Testbench for wb_arbiter2: directed scenarios with hand-computed expectations.
// dut runs with TIMEOUT=8, dutNt with the guard disabled; both share inputs.

module tb_wb_arbiter2;

  logic        sysClk = 1'b0;
  logic        sysRst;

  logic        m0Cyc, m0Stb, m0We, m1Cyc, m1Stb, m1We;
  logic [3:0]  m0Sel, m1Sel;
  logic [31:0] m0Adr, m0Mosi, m1Adr, m1Mosi;
  logic [31:0] m0Miso, m1Miso;
  logic        m0Ack, m0Err, m1Ack, m1Err;
  logic        sCyc, sStb, sWe;
  logic [3:0]  sSel;
  logic [31:0] sAdr, sMosi;

  logic [31:0] ntM0Miso, ntM1Miso;
  logic        ntM0Ack, ntM0Err, ntM1Ack, ntM1Err;
  logic        ntSCyc, ntSStb, ntSWe;
  logic [3:0]  ntSSel;
  logic [31:0] ntSAdr, ntSMosi;

  logic [31:0] sMisoIn;
  logic        sAckIn;
  logic        sErrIn;

  int          vecCount = 0;
  int          missCount = 0;

  // Slave model: 0 = registered ack held while stb, 1 = never acks, 2 = manual.
  int          slaveMode = 0;
  logic        modelAck;
  logic [31:0] modelMiso;
  logic [31:0] mem [0:15];
  logic        manualAck = 1'b0;
  logic [31:0] manualMiso = 32'h0;

  always #5 sysClk = ~sysClk;

  wb_arbiter2 #(.ADDR_WIDTH(32), .TIMEOUT(8)) dut (
    .sys_clk_i(sysClk), .sys_rst_i(sysRst),
    .m0_cyc_i(m0Cyc), .m0_stb_i(m0Stb), .m0_we_i(m0We), .m0_sel_i(m0Sel),
    .m0_adr_i(m0Adr), .m0_mosi_i(m0Mosi), .m0_miso_o(m0Miso), .m0_ack_o(m0Ack), .m0_err_o(m0Err),
    .m1_cyc_i(m1Cyc), .m1_stb_i(m1Stb), .m1_we_i(m1We), .m1_sel_i(m1Sel),
    .m1_adr_i(m1Adr), .m1_mosi_i(m1Mosi), .m1_miso_o(m1Miso), .m1_ack_o(m1Ack), .m1_err_o(m1Err),
    .s_cyc_o(sCyc), .s_stb_o(sStb), .s_we_o(sWe), .s_sel_o(sSel), .s_adr_o(sAdr),
    .s_mosi_o(sMosi), .s_miso_i(sMisoIn), .s_ack_i(sAckIn), .s_err_i(sErrIn)
  );

  wb_arbiter2 #(.ADDR_WIDTH(32), .TIMEOUT(0)) dutNt (
    .sys_clk_i(sysClk), .sys_rst_i(sysRst),
    .m0_cyc_i(m0Cyc), .m0_stb_i(m0Stb), .m0_we_i(m0We), .m0_sel_i(m0Sel),
    .m0_adr_i(m0Adr), .m0_mosi_i(m0Mosi), .m0_miso_o(ntM0Miso), .m0_ack_o(ntM0Ack), .m0_err_o(ntM0Err),
    .m1_cyc_i(m1Cyc), .m1_stb_i(m1Stb), .m1_we_i(m1We), .m1_sel_i(m1Sel),
    .m1_adr_i(m1Adr), .m1_mosi_i(m1Mosi), .m1_miso_o(ntM1Miso), .m1_ack_o(ntM1Ack), .m1_err_o(ntM1Err),
    .s_cyc_o(ntSCyc), .s_stb_o(ntSStb), .s_we_o(ntSWe), .s_sel_o(ntSSel), .s_adr_o(ntSAdr),
    .s_mosi_o(ntSMosi), .s_miso_i(sMisoIn), .s_ack_i(sAckIn), .s_err_i(sErrIn)
  );

  // Registered-ack slave following the TIMEOUT=8 instance's bus.
  always @(posedge sysClk) begin
    if (sysRst) begin
      modelAck <= 1'b0;
    end else begin
      modelAck <= sStb & (modelAck | (slaveMode == 0));
      if (sStb && !modelAck && slaveMode == 0) begin
        modelMiso <= mem[sAdr[5:2]];
        if (sWe) mem[sAdr[5:2]] <= sMosi;
      end
    end
  end

  assign sAckIn  = (slaveMode == 2) ? manualAck : modelAck;
  assign sMisoIn = (slaveMode == 2) ? manualMiso : modelMiso;
  assign sErrIn  = 1'b0;

  task automatic cyc();
    @(posedge sysClk);
    #2;
  endtask

  task automatic setMaster(input int m, input logic c, input logic s, input logic we,
                           input logic [31:0] adr, input logic [31:0] data);
    if (m == 0) begin
      m0Cyc = c; m0Stb = s; m0We = we; m0Sel = 4'hF; m0Adr = adr; m0Mosi = data;
    end else begin
      m1Cyc = c; m1Stb = s; m1We = we; m1Sel = 4'hF; m1Adr = adr; m1Mosi = data;
    end
  endtask

  // One single-beat transfer; lat counts edges from request to ack (-1 = none).
  task automatic masterOp(input int m, input logic we, input logic [31:0] adr,
                          input logic [31:0] data, output logic [31:0] rdata, output int lat);
    rdata = 32'h0;
    lat = -1;
    setMaster(m, 1'b1, 1'b1, we, adr, data);
    for (int i = 1; i <= 60; i++) begin
      cyc();
      if ((m == 0 && m0Ack) || (m == 1 && m1Ack)) begin
        lat = i;
        rdata = (m == 0) ? m0Miso : m1Miso;
        break;
      end
    end
    setMaster(m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
  endtask

  task automatic applyReset();
    sysRst = 1'b1;
    cyc();
    cyc();
    sysRst = 1'b0;
  endtask

  task automatic test_reset();
    setMaster(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    setMaster(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    sysRst = 1'b1;
    cyc();
    cyc();
    vecCount++;
    if ({sCyc, sStb, m0Ack, m0Err, m1Ack, m1Err} !== 6'b0) begin
      missCount++;
      $display("[TB] FAIL reset_ctl: got %b expected 000000", {sCyc, sStb, m0Ack, m0Err, m1Ack, m1Err});
    end
    vecCount++;
    if ({m0Miso, m1Miso} !== 64'h0) begin
      missCount++;
      $display("[TB] FAIL reset_miso: got %h expected 0", {m0Miso, m1Miso});
    end
    setMaster(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    sysRst = 1'b0;
    cyc();
  endtask

  task automatic test_single();
    logic [31:0] rd;
    int lat;
    int m1AckSeen;
    m1AckSeen = 0;
    setMaster(0, 1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    #1;
    vecCount++;
    if (sCyc !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL arb_latency0: s_cyc got %b expected 0", sCyc);
    end
    cyc();
    vecCount++;
    if (sCyc !== 1'b1 || sAdr !== 32'h10 || sWe !== 1'b1 || sMosi !== 32'hDEADBEEF) begin
      missCount++;
      $display("[TB] FAIL arb_latency1: cyc/adr/we/mosi got %b/%h/%b/%h expected 1/10/1/deadbeef",
               sCyc, sAdr, sWe, sMosi);
    end
    lat = -1;
    for (int i = 2; i <= 20; i++) begin
      cyc();
      if (m1Ack) m1AckSeen++;
      if (m0Ack) begin
        lat = i;
        break;
      end
    end
    setMaster(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    vecCount++;
    if (lat !== 2) begin
      missCount++;
      $display("[TB] FAIL write_ack_lat: got %0d expected 2", lat);
    end
    masterOp(0, 1'b0, 32'h10, 32'h0, rd, lat);
    if (m1Ack) m1AckSeen++;
    vecCount++;
    if (rd !== 32'hDEADBEEF || lat !== 2) begin
      missCount++;
      $display("[TB] FAIL read_back: data %h lat %0d expected deadbeef lat 2", rd, lat);
    end
    vecCount++;
    if (m1AckSeen !== 0) begin
      missCount++;
      $display("[TB] FAIL m1_ack_quiet: got %0d acks expected 0", m1AckSeen);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] rd0, rd1;
    int lat0, lat1;
    logic idleCyc;
    for (int round = 0; round < 2; round++) begin
      idleCyc = 1'b1;
      fork
        masterOp(0, 1'b1, 32'h4, 32'h1111_0000 + round, rd0, lat0);
        masterOp(1, 1'b1, 32'h8, 32'h2222_0000 + round, rd1, lat1);
        begin
          repeat (3) cyc();
          #1;
          idleCyc = sCyc;
        end
      join
      vecCount++;
      if (lat0 !== 2 || lat1 !== 5) begin
        missCount++;
        $display("[TB] FAIL rr_round%0d: lat m0 %0d m1 %0d expected 2 and 5", round, lat0, lat1);
      end
      vecCount++;
      if (idleCyc !== 1'b0) begin
        missCount++;
        $display("[TB] FAIL rr_idle_gap%0d: s_cyc got %b expected 0", round, idleCyc);
      end
    end
  endtask

  task automatic test_burst();
    logic [31:0] rd1;
    int lat1;
    int beats;
    int m1Early;
    beats = 0;
    m1Early = 0;
    fork
      begin
        m0Cyc = 1'b1;
        for (int b = 0; b < 4; b++) begin
          setMaster(0, 1'b1, 1'b1, 1'b1, 32'h20 + 4 * b, 32'hB000 + b);
          for (int i = 0; i < 20; i++) begin
            cyc();
            if (m1Ack) m1Early++;
            if (m0Ack) begin
              beats++;
              break;
            end
          end
          m0Stb = 1'b0;
          if (b == 3) m0Cyc = 1'b0;
          cyc();
        end
      end
      masterOp(1, 1'b0, 32'h10, 32'h0, rd1, lat1);
    join
    vecCount++;
    if (beats !== 4 || m1Early !== 0) begin
      missCount++;
      $display("[TB] FAIL burst_beats: beats %0d m1 acks %0d expected 4 and 0", beats, m1Early);
    end
    vecCount++;
    if (lat1 !== 11 || rd1 !== 32'hDEADBEEF) begin
      missCount++;
      $display("[TB] FAIL burst_m1_after: lat %0d data %h expected 11 deadbeef", lat1, rd1);
    end
  endtask

  task automatic test_timeout();
    int stbCycles;
    logic hit;
    int heldBad;
    logic [31:0] rd;
    int lat;
    stbCycles = 0;
    hit = 1'b0;
    heldBad = 0;
    slaveMode = 1;
    setMaster(0, 1'b1, 1'b1, 1'b0, 32'h24, 32'h0);
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (m0Err) begin
        hit = 1'b1;
        break;
      end
      if (sStb) stbCycles++;
    end
    vecCount++;
    if (!hit || stbCycles !== 8 || sStb !== 1'b0 || m0Ack !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL timeout_hit: err %b stb cycles %0d s_stb %b ack %b expected 1 8 0 0",
               hit, stbCycles, sStb, m0Ack);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (m0Err !== 1'b1 || sStb !== 1'b0) heldBad++;
    end
    vecCount++;
    if (heldBad !== 0) begin
      missCount++;
      $display("[TB] FAIL timeout_hold: got %0d bad cycles expected 0", heldBad);
    end
    m0Stb = 1'b0;
    #1;
    vecCount++;
    if (m0Err !== 1'b0) begin
      missCount++;
      $display("[TB] FAIL timeout_release: err got %b expected 0", m0Err);
    end
    m0Cyc = 1'b0;
    cyc();
    slaveMode = 0;
    masterOp(1, 1'b0, 32'h10, 32'h0, rd, lat);
    vecCount++;
    if (rd !== 32'hDEADBEEF || lat !== 2) begin
      missCount++;
      $display("[TB] FAIL timeout_m1_after: data %h lat %0d expected deadbeef lat 2", rd, lat);
    end
  endtask

  task automatic test_reset_mid();
    slaveMode = 1;
    setMaster(1, 1'b1, 1'b1, 1'b1, 32'h30, 32'h5);
    cyc();
    vecCount++;
    if (sCyc !== 1'b1 || sAdr !== 32'h30) begin
      missCount++;
      $display("[TB] FAIL rst_mid_own1: cyc %b adr %h expected 1 30", sCyc, sAdr);
    end
    sysRst = 1'b1;
    cyc();
    sysRst = 1'b0;
    setMaster(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
    #1;
    vecCount++;
    if ({sCyc, sStb, m1Ack, m1Err} !== 4'b0) begin
      missCount++;
      $display("[TB] FAIL rst_mid_idle: cyc/stb/ack/err got %b expected 0000", {sCyc, sStb, m1Ack, m1Err});
    end
    cyc();
    vecCount++;
    if (sCyc !== 1'b1 || sAdr !== 32'h40) begin
      missCount++;
      $display("[TB] FAIL rst_mid_tie: cyc %b adr %h expected 1 40 (m0)", sCyc, sAdr);
    end
    setMaster(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    setMaster(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    cyc();
    slaveMode = 0;
  endtask

  task automatic test_no_timeout();
    int errSeen;
    int ackEarly;
    errSeen = 0;
    ackEarly = 0;
    applyReset();
    slaveMode = 2;
    manualAck = 1'b0;
    setMaster(0, 1'b1, 1'b1, 1'b0, 32'h44, 32'h0);
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (ntM0Err) errSeen++;
      if (ntM0Ack) ackEarly++;
    end
    vecCount++;
    if (errSeen !== 0 || ackEarly !== 0 || ntSStb !== 1'b1) begin
      missCount++;
      $display("[TB] FAIL nt_wait: err %0d ack %0d stb %b expected 0 0 1", errSeen, ackEarly, ntSStb);
    end
    manualMiso = 32'h12345678;
    manualAck = 1'b1;
    #1;
    vecCount++;
    if (ntM0Ack !== 1'b1 || ntM0Err !== 1'b0 || ntM0Miso !== 32'h12345678) begin
      missCount++;
      $display("[TB] FAIL nt_late_ack: ack %b err %b data %h expected 1 0 12345678",
               ntM0Ack, ntM0Err, ntM0Miso);
    end
    setMaster(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    manualAck = 1'b0;
    slaveMode = 0;
    cyc();
  endtask

  initial begin
    sysRst = 1'b1;
    setMaster(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    setMaster(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_single();
    applyReset();
    test_round_robin();
    test_burst();
    test_timeout();
    test_reset_mid();
    test_no_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
